// File: rtl/multu_hilo_if.sv
// ---------------------------------------------------------------------------
// multu_hilo_if
// Bundle between ALU control / the result MUX and the Hi/Lo multiplier.
//   signal  : 6-bit function/select code from ALU control
//   dataA   : multiplicand (rs)
//   dataB   : multiplier (rt)
//   busy    : multiplier is iterating
//   done    : product valid, waiting for (or after) a Hi/Lo write
//   hi, lo  : architectural Hi/Lo registers
//   result  : Hi or Lo for MFHI/MFLO, otherwise zero
// master = ALU control / EX stage side, slave = the multiplier.
// ---------------------------------------------------------------------------
interface multu_hilo_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output signal, dataA, dataB,
    input  busy, done, hi, lo, result
  );

  modport slave (
    input  signal, dataA, dataB,
    output busy, done, hi, lo, result
  );
endinterface

// File: rtl/multu_hilo.sv
// ---------------------------------------------------------------------------
// multu_hilo
// Sequential unsigned shift-add multiplier feeding the Hi/Lo register pair.
// A MULTU code starts a WIDTH-cycle multiply, the HiLo-write code commits
// the finished product into Hi/Lo, and MFHI/MFLO select Hi or Lo onto the
// combinational result output.
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : multu_hilo_if slave (signal, dataA, dataB in;
//          busy, done, hi, lo, result out)
// ---------------------------------------------------------------------------
module multu_hilo #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] OP_MULTU   = 6'b011001,
  parameter logic [5:0] OP_HILO_WR = 6'b111111,
  parameter logic [5:0] OP_MFHI    = 6'b010000,
  parameter logic [5:0] OP_MFLO    = 6'b010010
) (
  input logic         clk,
  input logic         rst,
  multu_hilo_if.slave bus
);

  localparam int            CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [CW-1:0]        count_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH:0]       sum_d;
  logic                 keepGoing;

  // Upper half of the partial product plus the multiplicand when the current
  // multiplier bit (product LSB) is set. One extra bit keeps the carry so it
  // can be shifted into the product MSB.
  always_comb begin
    sum_d = {1'b0, product_q[2*WIDTH-1:WIDTH]};
    if (product_q[0]) begin
      sum_d = sum_d + {1'b0, mcand_q};
    end
  end

  // MULTU and HiLo-write are the only codes that keep a multiply alive;
  // anything else aborts a running multiply or leaves DONE.
  assign keepGoing = (bus.signal == OP_MULTU) || (bus.signal == OP_HILO_WR);

  // Control FSM and datapath. busy/done are registered alongside the state
  // so they are glitch-free. A held MULTU in DONE must not restart, which is
  // why a new multiply is only accepted from IDLE. Hi/Lo are written only
  // from DONE, so an early HiLo write while iterating is silently dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      product_q <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.signal == OP_MULTU) begin
            mcand_q   <= bus.dataA;
            product_q <= {{WIDTH{1'b0}}, bus.dataB};
            count_q   <= '0;
            state_q   <= RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        RUN: begin
          if (keepGoing) begin
            product_q <= {sum_d, product_q[WIDTH-1:1]};
            count_q   <= count_q + CW'(1);
            if (count_q == LAST_ITER) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          if (bus.signal == OP_HILO_WR) begin
            hi_q <= product_q[2*WIDTH-1:WIDTH];
            lo_q <= product_q[WIDTH-1:0];
          end
          if (!keepGoing) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Result MUX leg: no added latency, so an MFHI/MFLO sees Hi/Lo as they
  // stand before any write on the same edge.
  always_comb begin
    bus.result = '0;
    if (bus.signal == OP_MFHI) begin
      bus.result = hi_q;
    end else if (bus.signal == OP_MFLO) begin
      bus.result = lo_q;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_multu_hilo.sv
// ---------------------------------------------------------------------------
// tb_multu_hilo
// Self-checking bench for multu_hilo: a table of known products, randomized
// operands checked against a 64-bit arithmetic reference, and hand-written
// sequences for early commit, abort, reset mid-operation and held MULTU.
// ---------------------------------------------------------------------------
module tb_multu_hilo;

  localparam int         WIDTH      = 32;
  localparam logic [5:0] OP_MULTU   = 6'b011001;
  localparam logic [5:0] OP_HILO_WR = 6'b111111;
  localparam logic [5:0] OP_MFHI    = 6'b010000;
  localparam logic [5:0] OP_MFLO    = 6'b010010;
  localparam logic [5:0] OP_ADD     = 6'b100000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] modelHi;
  logic [31:0] modelLo;

  vec_t vecs[7];

  multu_hilo_if #(.WIDTH(WIDTH)) bus ();

  multu_hilo #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it when the values differ.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive the request side of the interface.
  task automatic applyStimulus(input logic [5:0] code, input logic [31:0] a,
                               input logic [31:0] b);
    bus.signal = code;
    bus.dataA  = a;
    bus.dataB  = b;
  endtask

  // Start a multiply from IDLE and hold MULTU until done, with a cycle bound.
  task automatic runMultiply(input logic [31:0] a, input logic [31:0] b,
                             output int busyCycles, output bit finished);
    applyStimulus(OP_MULTU, a, b);
    busyCycles = 0;
    finished   = 1'b0;
    for (int i = 0; i < WIDTH + 8 && !finished; i++) begin
      tick();
      if (bus.busy) busyCycles++;
      if (bus.done) finished = 1'b1;
    end
  endtask

  // One HiLo-write edge; the reference model takes the expected product.
  task automatic commitProduct(input logic [63:0] prod);
    applyStimulus(OP_HILO_WR, 32'h0, 32'h0);
    tick();
    modelHi = prod[63:32];
    modelLo = prod[31:0];
  endtask

  // Hi/Lo registers and all three result MUX decodes against the model.
  task automatic checkHiLo(input string name);
    checkOutput({name, " hi"}, 64'(bus.hi), 64'(modelHi));
    checkOutput({name, " lo"}, 64'(bus.lo), 64'(modelLo));
    applyStimulus(OP_MFHI, 32'h0, 32'h0);
    #1;
    checkOutput({name, " result MFHI"}, 64'(bus.result), 64'(modelHi));
    applyStimulus(OP_MFLO, 32'h0, 32'h0);
    #1;
    checkOutput({name, " result MFLO"}, 64'(bus.result), 64'(modelLo));
    applyStimulus(OP_ADD, 32'h0, 32'h0);
    #1;
    checkOutput({name, " result other"}, 64'(bus.result), 64'h0);
  endtask

  // Drop back to IDLE with a neutral code.
  task automatic goIdle();
    applyStimulus(OP_ADD, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    int          busyCycles;
    bit          finished;
    int          bad;
    logic [31:0] ra;
    logic [31:0] rb;

    checks  = 0;
    errors  = 0;
    modelHi = '0;
    modelLo = '0;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          expHi: 32'h0,        expLo: 32'd15};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   expHi: 32'hFFFFFFFE, expLo: 32'h00000001};
    vecs[2] = '{a: 32'd7,          b: 32'd6,          expHi: 32'h0,        expLo: 32'd42};
    vecs[3] = '{a: 32'h00010000,   b: 32'h00010000,   expHi: 32'h1,        expLo: 32'h0};
    vecs[4] = '{a: 32'h80000000,   b: 32'd2,          expHi: 32'h1,        expLo: 32'h0};
    vecs[5] = '{a: 32'hFFFFFFFF,   b: 32'd2,          expHi: 32'h1,        expLo: 32'hFFFFFFFE};
    vecs[6] = '{a: 32'h0,          b: 32'hDEADBEEF,   expHi: 32'h0,        expLo: 32'h0};

    // Reset for two cycles.
    applyStimulus(OP_ADD, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset busy", 64'(bus.busy), 64'h0);
    checkOutput("reset done", 64'(bus.done), 64'h0);
    checkHiLo("reset");

    // Table-driven known products, including exact busy length.
    for (int i = 0; i < 7; i++) begin
      runMultiply(vecs[i].a, vecs[i].b, busyCycles, finished);
      checkOutput($sformatf("vec%0d done reached", i), 64'(finished), 64'h1);
      checkOutput($sformatf("vec%0d busy cycles", i), 64'(busyCycles), 64'(WIDTH));
      commitProduct({vecs[i].expHi, vecs[i].expLo});
      checkHiLo($sformatf("vec%0d", i));
      goIdle();
    end

    // Randomized operands against plain 64-bit arithmetic.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'hFFFFFFFF;
      if (i == 1) rb = 32'h1;
      runMultiply(ra, rb, busyCycles, finished);
      checkOutput($sformatf("rand%0d done reached", i), 64'(finished), 64'h1);
      commitProduct(64'(ra) * 64'(rb));
      checkHiLo($sformatf("rand%0d", i));
      goIdle();
    end

    // Leaving DONE without a write discards the product: a later HiLo write
    // from IDLE must not touch Hi/Lo.
    runMultiply(32'd1000, 32'd1000, busyCycles, finished);
    goIdle();
    checkOutput("no-commit done cleared", 64'(bus.done), 64'h0);
    applyStimulus(OP_HILO_WR, 32'h0, 32'h0);
    tick();
    checkHiLo("idle write ignored");
    goIdle();

    // Repeated HiLo writes are idempotent.
    runMultiply(32'd9, 32'd11, busyCycles, finished);
    commitProduct(64'd99);
    commitProduct(64'd99);
    checkOutput("double commit done", 64'(bus.done), 64'h1);
    checkHiLo("double commit");
    goIdle();

    // Early commit while iterating: ignored, multiply keeps running.
    applyStimulus(OP_MULTU, 32'd7, 32'd6);
    tick();
    for (int i = 0; i < 10; i++) tick();
    applyStimulus(OP_HILO_WR, 32'h0, 32'h0);
    tick();
    checkOutput("early commit busy", 64'(bus.busy), 64'h1);
    checkOutput("early commit hi", 64'(bus.hi), 64'(modelHi));
    checkOutput("early commit lo", 64'(bus.lo), 64'(modelLo));
    applyStimulus(OP_MULTU, 32'd7, 32'd6);
    finished = 1'b0;
    for (int i = 0; i < WIDTH + 8 && !finished; i++) begin
      tick();
      if (bus.done) finished = 1'b1;
    end
    checkOutput("early commit done reached", 64'(finished), 64'h1);
    commitProduct(64'd42);
    checkHiLo("early commit");
    goIdle();

    // Abort with another code mid-run; Hi/Lo keep their prior values.
    applyStimulus(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
    tick();
    for (int i = 0; i < 20; i++) tick();
    applyStimulus(OP_ADD, 32'h0, 32'h0);
    tick();
    checkOutput("abort busy", 64'(bus.busy), 64'h0);
    checkOutput("abort done", 64'(bus.done), 64'h0);
    checkHiLo("abort");
    runMultiply(32'h12345678, 32'h9ABCDEF0, busyCycles, finished);
    checkOutput("after abort done reached", 64'(finished), 64'h1);
    checkOutput("after abort busy cycles", 64'(busyCycles), 64'(WIDTH));
    commitProduct(64'(32'h12345678) * 64'(32'h9ABCDEF0));
    checkHiLo("after abort");
    goIdle();

    // Reset in the middle of a multiply clears everything.
    applyStimulus(OP_MULTU, 32'd123, 32'd456);
    tick();
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelHi = '0;
    modelLo = '0;
    checkOutput("mid reset busy", 64'(bus.busy), 64'h0);
    checkOutput("mid reset done", 64'(bus.done), 64'h0);
    checkHiLo("mid reset");

    // Held MULTU after done must not restart; the product stays committable.
    runMultiply(32'hFFFFFFFF, 32'hFFFFFFFF, busyCycles, finished);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(OP_MULTU, 32'h1, 32'h1);
      tick();
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    checkOutput("held multu bad cycles", 64'(bad), 64'h0);
    commitProduct({32'hFFFFFFFE, 32'h00000001});
    checkHiLo("held multu");
    goIdle();
    checkOutput("held multu released", 64'(bus.done), 64'h0);
    runMultiply(32'h0, 32'hDEADBEEF, busyCycles, finished);
    checkOutput("zero operand done reached", 64'(finished), 64'h1);
    commitProduct(64'h0);
    checkHiLo("zero operand");
    goIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
